arbitro_3: RTL and testbench
============================

# arbitro_3

Round-robin arbiter that shares one downstream consumer among three upstream producers, all using the dav_/rfd handshake. It acts as the consumer toward each producer and as the producer toward the single downstream port. It forwards one byte per grant, tagged with the index of its source. It sits between the acquisition front-ends (e.g. ABC-style units) and a single consumer.

## Interface
- No parameters; data width fixed at 8.
- clock  in  1  system clock, all state updates on posedge
- reset_  in  1  asynchronous, active-low reset
- dav1_, dav2_, dav3_  in  1  producer N data-valid, active low
- x1, x2, x3  in  8  producer N data; stable while davN_=0
- rfd1, rfd2, rfd3  out  1  ready-for-data to producer N
- dav_  out  1  data-valid to consumer, active low
- rfd  in  1  consumer ready-for-data
- out  out  8  forwarded byte
- src  out  2  source of out: 1, 2 or 3; 0 = nothing forwarded since reset
- min  out  8  present only with MIN_EN (see Configuration)

## Operation
- Reset values: rfd1=rfd2=rfd3=1, dav_=1, out=8'h00, src=2'd0, LAST=3, STAR=IDLE, min=8'hFF (if present).
- LAST (2 bits) holds the last granted index; priority order is LAST+1, LAST+2, LAST+3 (mod 3, range 1..3).
- The FSM has four states:
  - IDLE:
    - if no davN_=0, stay in IDLE.
    - otherwise grant K, the first requester in priority order.
    - out<=xK, src<=K, LAST<=K, rfdK<=0, go to WREL.
  - WREL: wait for davK_=1, then rfdK<=1, dav_<=0, go to WACK.
  - WACK: wait for rfd=0, then dav_<=1, go to WEND.
  - WEND: wait for rfd=1, then go to IDLE.
- Non-granted producers keep their rfd at 1. Their davN_ stays low and their data stays held until they are granted; there is no timeout.
- Only one rfdN is ever 0 at a time. rfdN=0 only for the granted K, only in WREL.
- out and src change only on the IDLE grant edge. They hold through the whole downstream handshake and afterwards.
- The arbiter sees only the registered K; inputs of non-granted producers are ignored.

## Timing
- Grant latency: davK_ sampled low at edge t, with STAR=IDLE, gives rfdK=0, out and src valid after edge t.
- Release: davK_ sampled high at edge t gives rfdK=1 and dav_=0 after edge t. out is therefore valid at least one cycle before dav_ falls.
- Consumer ack: rfd sampled 0 gives dav_=1 on the next edge. rfd sampled 1 in WEND gives IDLE on the next edge.
- Minimum full transaction: 4 clocks. Back-to-back grants: the next grant is evaluated in the IDLE cycle following WEND.
- Simultaneous requests are resolved purely by LAST. Three permanent requesters are served 1,2,3,1,2,3…
- Reset mid-transaction: all outputs return to their reset values immediately (asynchronously).
  - A producer in WREL sees rfdK return to 1.
  - A consumer in WACK/WEND sees dav_ return to 1.
  - The transaction is lost and not replayed.
- Producer dropping davN_ back to 1 before its grant is a protocol violation: unspecified, but the FSM must not lock up.

## Configuration
- MIN_EN defined:
  - adds output min[7:0], the running minimum of all bytes forwarded since reset.
  - reset value is 8'hFF.
  - updated on the IDLE grant edge: min<=(xK<min)?xK:min.
  - the comparison uses the borrow-out of the team's 8-bit sottrattore, with b_in=0.
- MIN_EN undefined: min port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset check: reset_=0 mid-simulation gives rfd1..3=1, dav_=1, src=0, out=0, min=FF, regardless of clock.
- Single producer 2 sends x2=8'h55:
  - rfd2=0 one edge after dav2_ falls.
  - dav_=0 one edge after dav2_ rises, with out=55 and src=2.
  - dav_=1 one edge after rfd=0.
- Producers 1,2,3 request simultaneously with 8'h10,20,30, and each re-requests immediately after release: grants go 1,2,3,1 with the matching out values; rfd1..3 never 0 concurrently.
- Producers 1 and 3 request permanently: grants alternate 1,3,1,3.
- Consumer holds rfd=1 for 10 cycles after dav_ falls:
  - dav_ stays 0 and out stays stable.
  - a pending dav2_ request receives no grant until WEND→IDLE.
- reset_ pulsed while in WACK: dav_=1 immediately; next grant honours LAST=3, so priority starts at 1. With MIN_EN, forwarding 8'h40, 8'h90, 8'h07 gives min=40, 40, 07.

Source files
------------

// File: rtl/arbitro_3.sv
// arbitro_3: round-robin arbiter forwarding one byte per grant from three dav_/rfd producers to one consumer.
// Define MIN_EN to add output min, the running minimum of all forwarded bytes.
module arbitro_3 (
  input  logic       clock,
  input  logic       reset_,
  input  logic       dav1_,
  input  logic       dav2_,
  input  logic       dav3_,
  input  logic [7:0] x1,
  input  logic [7:0] x2,
  input  logic [7:0] x3,
  output logic       rfd1,
  output logic       rfd2,
  output logic       rfd3,
  output logic       dav_,
  input  logic       rfd,
  output logic [7:0] out,
  output logic [1:0] src
`ifdef MIN_EN
  ,output logic [7:0] min
`endif
);

  typedef enum logic [1:0] {IDLE, WREL, WACK, WEND} state_t;

  state_t     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [1:0] src_q, src_d;
  logic [2:0] rfd_q, rfd_d;
  logic       dav_q, dav_d;
  logic [7:0] out_q, out_d;

  logic [3:0] req;
  logic [1:0] p0, p1, p2;
  logic [1:0] grant;
  logic [7:0] x_grant;
  logic       dav_k;

  // Bit 0 is a permanent zero so producer numbers index the vector directly.
  assign req = {~dav3_, ~dav2_, ~dav1_, 1'b0};

  always_comb begin
    p0 = 2'd1;
    p1 = 2'd2;
    p2 = 2'd3;
    case (last_q)
      2'd1: begin p0 = 2'd2; p1 = 2'd3; p2 = 2'd1; end
      2'd2: begin p0 = 2'd3; p1 = 2'd1; p2 = 2'd2; end
      default: ;
    endcase
    grant = 2'd0;
    if (req[p0])      grant = p0;
    else if (req[p1]) grant = p1;
    else if (req[p2]) grant = p2;
  end

  always_comb begin
    x_grant = 8'h00;
    case (grant)
      2'd1:    x_grant = x1;
      2'd2:    x_grant = x2;
      2'd3:    x_grant = x3;
      default: ;
    endcase
  end

  // Only the registered winner's dav_ is watched after the grant.
  always_comb begin
    dav_k = 1'b1;
    case (src_q)
      2'd1:    dav_k = dav1_;
      2'd2:    dav_k = dav2_;
      2'd3:    dav_k = dav3_;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    src_d   = src_q;
    rfd_d   = rfd_q;
    dav_d   = dav_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (grant != 2'd0) begin
          out_d   = x_grant;
          src_d   = grant;
          last_d  = grant;
          state_d = WREL;
          case (grant)
            2'd1:    rfd_d = 3'b110;
            2'd2:    rfd_d = 3'b101;
            default: rfd_d = 3'b011;
          endcase
        end
      end
      WREL: begin
        if (dav_k) begin
          rfd_d   = 3'b111;
          dav_d   = 1'b0;
          state_d = WACK;
        end
      end
      WACK: begin
        if (!rfd) begin
          dav_d   = 1'b1;
          state_d = WEND;
        end
      end
      WEND: begin
        if (rfd) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      src_q   <= 2'd0;
      rfd_q   <= 3'b111;
      dav_q   <= 1'b1;
      out_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      src_q   <= src_d;
      rfd_q   <= rfd_d;
      dav_q   <= dav_d;
      out_q   <= out_d;
    end
  end

  assign rfd1 = rfd_q[0];
  assign rfd2 = rfd_q[1];
  assign rfd3 = rfd_q[2];
  assign dav_ = dav_q;
  assign out  = out_q;
  assign src  = src_q;

`ifdef MIN_EN
  logic [7:0] min_q, min_d;
  logic       borrow;

  // Ripple borrow chain of x_grant - min_q with zero borrow-in; borrow-out means x_grant < min_q.
  always_comb begin
    borrow = 1'b0;
    for (int i = 0; i < 8; i++) begin
      borrow = (~x_grant[i] & min_q[i]) | (~(x_grant[i] ^ min_q[i]) & borrow);
    end
    min_d = min_q;
    if (state_q == IDLE && grant != 2'd0 && borrow) min_d = x_grant;
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) min_q <= 8'hFF;
    else         min_q <= min_d;
  end

  assign min = min_q;
`endif

endmodule

// File: tb/tb_arbitro_3.sv
// Directed self-checking bench for arbitro_3: handshake timing, round-robin order, stalls, async reset.
// Build with MIN_EN defined to also check the running minimum.
module tb_arbitro_3;

  logic       clock = 1'b0;
  logic       reset_;
  logic       dav1_, dav2_, dav3_;
  logic [7:0] x1, x2, x3;
  logic       rfd1, rfd2, rfd3;
  logic       dav_;
  logic       rfd;
  logic [7:0] out;
  logic [1:0] src;
`ifdef MIN_EN
  logic [7:0] min;
`endif

  int total = 0;
  int bad   = 0;
  logic [2:0] davVec;

  arbitro_3 dut (
    .clock  (clock),
    .reset_ (reset_),
    .dav1_  (dav1_),
    .dav2_  (dav2_),
    .dav3_  (dav3_),
    .x1     (x1),
    .x2     (x2),
    .x3     (x3),
    .rfd1   (rfd1),
    .rfd2   (rfd2),
    .rfd3   (rfd3),
    .dav_   (dav_),
    .rfd    (rfd),
    .out    (out),
    .src    (src)
`ifdef MIN_EN
    ,.min   (min)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] davs, input logic rfdIn);
    dav1_ = davs[0];
    dav2_ = davs[1];
    dav3_ = davs[2];
    rfd   = rfdIn;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [2:0] expRfd, input logic expDav,
                          input logic [7:0] expOut, input logic [1:0] expSrc);
    checkOutput({tag, ".rfd"}, {5'd0, rfd3, rfd2, rfd1}, {5'd0, expRfd});
    checkOutput({tag, ".dav_"}, {7'd0, dav_}, {7'd0, expDav});
    checkOutput({tag, ".out"}, out, expOut);
    checkOutput({tag, ".src"}, {6'd0, src}, {6'd0, expSrc});
  endtask

  task automatic checkMin(input string tag, input logic [7:0] expected);
`ifdef MIN_EN
    checkOutput({tag, ".min"}, min, expected);
`else
    if (tag.len() < 0) $display("[TB] %s %h", tag, expected);
`endif
  endtask

  // One full transaction for producer k, assumed to be the next winner.
  task automatic serveOne(input string tag, input int k, input logic [7:0] expOut, input bit rereq);
    logic [2:0] m;
    logic [1:0] ks;
    m = 3'b111;
    m[k-1] = 1'b0;
    ks = 2'(k);
    tick();
    checkAll($sformatf("%s.grant%0d", tag, k), m, 1'b1, expOut, ks);
    davVec[k-1] = 1'b1;
    applyStimulus(davVec, 1'b1);
    tick();
    checkAll($sformatf("%s.release%0d", tag, k), 3'b111, 1'b0, expOut, ks);
    if (rereq) davVec[k-1] = 1'b0;
    applyStimulus(davVec, 1'b0);
    tick();
    checkAll($sformatf("%s.ack%0d", tag, k), 3'b111, 1'b1, expOut, ks);
    applyStimulus(davVec, 1'b1);
    tick();
    checkAll($sformatf("%s.end%0d", tag, k), 3'b111, 1'b1, expOut, ks);
  endtask

  task automatic doReset();
    reset_ = 1'b0;
    tick();
    reset_ = 1'b1;
  endtask

  initial begin
    reset_ = 1'b1;
    davVec = 3'b111;
    applyStimulus(davVec, 1'b1);
    x1 = 8'h00; x2 = 8'h00; x3 = 8'h00;

    // Asynchronous reset, checked before any clock edge
    #2 reset_ = 1'b0;
    #1;
    checkAll("rst.async", 3'b111, 1'b1, 8'h00, 2'd0);
    checkMin("rst.async", 8'hFF);
    tick();
    checkAll("rst.clocked", 3'b111, 1'b1, 8'h00, 2'd0);
    reset_ = 1'b1;

    // Single producer 2 with a one-cycle stretched release
    x2 = 8'h55;
    davVec = 3'b101;
    applyStimulus(davVec, 1'b1);
    tick();
    checkAll("t1.grant", 3'b101, 1'b1, 8'h55, 2'd2);
    checkMin("t1.grant", 8'h55);
    tick();
    checkAll("t1.hold", 3'b101, 1'b1, 8'h55, 2'd2);
    davVec = 3'b111;
    applyStimulus(davVec, 1'b1);
    tick();
    checkAll("t1.release", 3'b111, 1'b0, 8'h55, 2'd2);
    applyStimulus(davVec, 1'b0);
    tick();
    checkAll("t1.ack", 3'b111, 1'b1, 8'h55, 2'd2);
    applyStimulus(davVec, 1'b1);
    tick();
    checkAll("t1.end", 3'b111, 1'b1, 8'h55, 2'd2);
    tick();
    checkAll("t1.idle", 3'b111, 1'b1, 8'h55, 2'd2);

    // Three permanent requesters after reset: 1,2,3,1,2,3
    doReset();
    x1 = 8'h10; x2 = 8'h20; x3 = 8'h30;
    davVec = 3'b000;
    applyStimulus(davVec, 1'b1);
    serveOne("t2", 1, 8'h10, 1'b1);
    serveOne("t2", 2, 8'h20, 1'b1);
    serveOne("t2", 3, 8'h30, 1'b1);
    serveOne("t2", 1, 8'h10, 1'b1);
    serveOne("t2", 2, 8'h20, 1'b1);
    serveOne("t2", 3, 8'h30, 1'b1);
    checkMin("t2", 8'h10);
    davVec = 3'b111;
    applyStimulus(davVec, 1'b1);
    tick();
    checkAll("t2.idle", 3'b111, 1'b1, 8'h30, 2'd3);

    // Producers 1 and 3 permanent: 1,3,1,3
    x1 = 8'h11; x3 = 8'h33;
    davVec = 3'b010;
    applyStimulus(davVec, 1'b1);
    serveOne("t3", 1, 8'h11, 1'b1);
    serveOne("t3", 3, 8'h33, 1'b1);
    serveOne("t3", 1, 8'h11, 1'b1);
    serveOne("t3", 3, 8'h33, 1'b1);
    davVec = 3'b111;
    applyStimulus(davVec, 1'b1);
    tick();

    // Consumer stalls 10 cycles while producer 2 waits
    x1 = 8'h77;
    davVec = 3'b110;
    applyStimulus(davVec, 1'b1);
    tick();
    checkAll("t4.grant", 3'b110, 1'b1, 8'h77, 2'd1);
    x2 = 8'h22;
    davVec = 3'b101;
    applyStimulus(davVec, 1'b1);
    tick();
    checkAll("t4.release", 3'b111, 1'b0, 8'h77, 2'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      checkAll($sformatf("t4.stall%0d", i), 3'b111, 1'b0, 8'h77, 2'd1);
    end
    applyStimulus(davVec, 1'b0);
    tick();
    checkAll("t4.ack", 3'b111, 1'b1, 8'h77, 2'd1);
    applyStimulus(davVec, 1'b1);
    tick();
    checkAll("t4.end", 3'b111, 1'b1, 8'h77, 2'd1);
    tick();
    checkAll("t4.grant2", 3'b101, 1'b1, 8'h22, 2'd2);
    davVec = 3'b111;
    applyStimulus(davVec, 1'b1);
    tick();
    checkAll("t4.release2", 3'b111, 1'b0, 8'h22, 2'd2);
    applyStimulus(davVec, 1'b0);
    tick();
    applyStimulus(davVec, 1'b1);
    tick();

    // Reset pulsed in WACK, then priority restarts at producer 1
    x2 = 8'h99;
    davVec = 3'b101;
    applyStimulus(davVec, 1'b1);
    tick();
    checkAll("t5.grant", 3'b101, 1'b1, 8'h99, 2'd2);
    davVec = 3'b111;
    applyStimulus(davVec, 1'b1);
    tick();
    checkAll("t5.wack", 3'b111, 1'b0, 8'h99, 2'd2);
    #2 reset_ = 1'b0;
    #1;
    checkAll("t5.async", 3'b111, 1'b1, 8'h00, 2'd0);
    checkMin("t5.async", 8'hFF);
    tick();
    reset_ = 1'b1;
    x1 = 8'h40; x2 = 8'h90; x3 = 8'h07;
    davVec = 3'b000;
    applyStimulus(davVec, 1'b1);
    serveOne("t5", 1, 8'h40, 1'b0);
    checkMin("t5.m1", 8'h40);
    serveOne("t5", 2, 8'h90, 1'b0);
    checkMin("t5.m2", 8'h40);
    serveOne("t5", 3, 8'h07, 1'b0);
    checkMin("t5.m3", 8'h07);
    tick();
    checkAll("t5.idle", 3'b111, 1'b1, 8'h07, 2'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
